speed_key_events: RTL
=====================

# speed_key_events

Front-end event generator for the playback speed path. Takes the three raw active-low speed push-buttons (faster, slower, nominal), synchronizes and debounces them, and produces the mutually exclusive single-cycle `speed_up_event`, `speed_down_event` and `speed_reset_event` strobes. These strobes drive the speed controller that sets the sample-clock divide count. Optional hold-to-repeat lets a held button step the speed continuously.

## Interface
- `DEBOUNCE_CYCLES`, 270000: consecutive stable synchronized cycles required to accept a level change (10 ms at 27 MHz); legal range ≥2.
- `REPEAT_DELAY`, 13500000: cycles from the initial event of a held key to its first repeat (500 ms).
- `REPEAT_RATE`, 2700000: cycles between subsequent repeats (100 ms).
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_up_n` in 1: raw button, low = pressed, asynchronous to `clk`.
- `key_down_n` in 1: raw button, low = pressed.
- `key_reset_n` in 1: raw button, low = pressed.
- `speed_up_event` out 1: one-cycle strobe.
- `speed_down_event` out 1: one-cycle strobe.
- `speed_reset_event` out 1: one-cycle strobe.
- `keys_held` out 3: debounced pressed state {reset, down, up}, 1 = pressed.

## Operation
- Each key has its own 2-flop synchronizer. The synchronizer output is inverted so that 1 = pressed.
- Each key has its own debounce counter. It counts while the synchronized level differs from the debounced state and clears to 0 whenever the levels match.
  - When the count reaches `DEBOUNCE_CYCLES-1`, the debounced state takes the new level and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced state.
- Press request: a 0→1 transition of a debounced state. A release (1→0) generates no event.
- Arbitration when several requests occur in the same cycle:
  - Priority is reset > down > up.
  - Losing requests are dropped, not deferred.
  - The outputs are guaranteed one-hot or all-zero in every cycle.
- All three event outputs are registered.
- `keys_held` is the debounced state, registered.
- Reset values: all outputs are 0; the synchronizers and debounced states are 0 (released); all counters are 0; the FSM is in IDLE.
- An asynchronous reset mid-debounce or mid-hold discards all progress. After release, a key already held low must re-qualify through the full debounce before it can generate an event.

## Timing
- Latency: raw key edge (stable thereafter) to event strobe is exactly `DEBOUNCE_CYCLES+3` rising clock edges: 2 for the synchronizer, `DEBOUNCE_CYCLES` for the debounce, 1 for the output register.
- Each strobe is high for exactly 1 cycle per press or repeat.
- Minimum spacing between two press events of the same key is `2*DEBOUNCE_CYCLES` cycles, because a release must also debounce.

## Configuration
- Macro: `SPEED_KEY_AUTOREPEAT_EN`.
- Defined: a repeat FSM is compiled in, using a single repeat counter.
  - IDLE → DELAY: on an up or down press event, when that key is the only debounced key held. The counter is loaded with `REPEAT_DELAY-1`.
  - DELAY → REPEAT: when the counter reaches 0. The held key's event is emitted and the counter is reloaded with `REPEAT_RATE-1`.
  - REPEAT → REPEAT: when the counter reaches 0. The held key's event is emitted and the counter is reloaded.
  - DELAY or REPEAT → IDLE: when `keys_held` changes in any way, including release of the held key, a second key pressed, or reset-key activity. Any press event arising from that same change is still arbitrated normally.
  - The reset key never repeats.
  - A repeat event and a press event never coincide; the press event wins and the FSM returns to IDLE that cycle.
- Undefined: no repeat logic. Exactly one event per debounced press. `REPEAT_DELAY` and `REPEAT_RATE` are unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_RATE=3`.
- Reset, then hold `key_up_n` low from cycle 0 → `speed_up_event` is high exactly at cycle 7 for 1 cycle, `keys_held`=3'b001; all outputs are 0 during reset.
- `key_down_n` pulsed low for 3 cycles, then high, repeated 5 times → no `speed_down_event`; `keys_held` stays 3'b000.
- `key_up_n` and `key_reset_n` fall on the same cycle → a single `speed_reset_event` at cycle 7, no `speed_up_event`; `keys_held`=3'b101.
- With `SPEED_KEY_AUTOREPEAT_EN`, hold `key_down_n` for 40 cycles → `speed_down_event` at cycles 7, 17, 20, 23, 26, …, then none after release.
- With `SPEED_KEY_AUTOREPEAT_EN`, hold `key_up_n`, then press `key_down_n` 12 cycles later → the up repeat stops, a down event fires on the down press, and no further repeats occur while both keys are held.
- Assert `rst_n` low mid-debounce (cycle 5 of an up press) while the key stays held → no event. After `rst_n` rises, an event occurs exactly `DEBOUNCE_CYCLES+3` edges later.

Source files
------------

// File: rtl/speed_key_events.sv
// Debounced speed-button event generator; raw key edge to strobe is DEBOUNCE_CYCLES+3 clocks, no backpressure.
// Define SPEED_KEY_AUTOREPEAT_EN to compile in hold-to-repeat for the up/down keys.
module speed_key_events #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_RATE     = 2700000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_reset_n,
    output logic       speed_up_event,
    output logic       speed_down_event,
    output logic       speed_reset_event,
    output logic [2:0] keys_held
);

    localparam int             DW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
        $error("speed_key_events: illegal parameter values");
    end

    // Key vectors are ordered {reset, down, up}, 1 = pressed.
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1, r_sync2, r_deb, r_held, r_ev;
    logic [DW-1:0] r_dcnt [3];
    logic [2:0]    w_press, w_ev_nxt;

    assign w_raw   = {~key_reset_n, ~key_down_n, ~key_up_n};
    assign w_press = r_deb & ~r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_held  <= '0;
            r_ev    <= '0;
            for (int k = 0; k < 3; k++) r_dcnt[k] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_held  <= r_deb;
            r_ev    <= w_ev_nxt;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_deb[k]) begin
                    if (r_dcnt[k] == DLAST) begin
                        r_deb[k]  <= r_sync2[k];
                        r_dcnt[k] <= '0;
                    end else begin
                        r_dcnt[k] <= r_dcnt[k] + DW'(1);
                    end
                end else begin
                    r_dcnt[k] <= '0;
                end
            end
        end
    end

`ifdef SPEED_KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t    r_state, w_state_nxt;
    logic [RW-1:0] r_rcnt, w_rcnt_nxt;
    logic          r_rep_dn, w_rep_dn_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rcnt   <= '0;
            r_rep_dn <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_rep_dn <= w_rep_dn_nxt;
        end
    end
`endif

    always_comb begin
        w_ev_nxt = 3'b000;
        if (w_press[2])      w_ev_nxt = 3'b100;
        else if (w_press[1]) w_ev_nxt = 3'b010;
        else if (w_press[0]) w_ev_nxt = 3'b001;
`ifdef SPEED_KEY_AUTOREPEAT_EN
        w_state_nxt  = r_state;
        w_rcnt_nxt   = r_rcnt;
        w_rep_dn_nxt = r_rep_dn;
        case (r_state)
            IDLE: begin
                // Only a lone up or down key arms the repeat.
                if ((w_ev_nxt == 3'b010 || w_ev_nxt == 3'b001) && r_deb == w_ev_nxt) begin
                    w_state_nxt  = DELAY;
                    w_rcnt_nxt   = RW'(REPEAT_DELAY - 1);
                    w_rep_dn_nxt = w_ev_nxt[1];
                end
            end
            default: begin
                // Any change of the held set cancels; a press in the same cycle still wins arbitration.
                if (r_deb != r_held) begin
                    w_state_nxt = IDLE;
                end else if (r_rcnt == '0) begin
                    w_ev_nxt    = r_rep_dn ? 3'b010 : 3'b001;
                    w_state_nxt = REPEAT;
                    w_rcnt_nxt  = RW'(REPEAT_RATE - 1);
                end else begin
                    w_rcnt_nxt  = r_rcnt - RW'(1);
                end
            end
        endcase
`endif
    end

    assign speed_up_event    = r_ev[0];
    assign speed_down_event  = r_ev[1];
    assign speed_reset_event = r_ev[2];
    assign keys_held         = r_held;

endmodule
